// File: rtl/i2s_rec_capture.sv
// I2S record-path receiver: oversamples bclk/lrc/data in the mclk domain, assembles
// left-aligned stereo words and queues completed {left,right} frames in a FWFT FIFO.
module i2s_rec_capture #(
    parameter int SAMPLE_BITS = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                           mclk,
    input  logic                           rstn,
    input  logic                           audio_I2S_bclk,
    input  logic                           audio_I2S_reclrc,
    input  logic                           audio_I2S_recdat,
    input  logic                           enable,
    input  logic                           rec_ready,
    output logic                           rec_valid,
    output logic signed [SAMPLE_BITS-1:0]  rec_left,
    output logic signed [SAMPLE_BITS-1:0]  rec_right,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    output logic                           overflow,
    input  logic                           clr_overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(SAMPLE_BITS + 1);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_t;

    logic [2:0]                    r_bclk_sync;
    logic [1:0]                    r_lrc_sync;
    logic [1:0]                    r_dat_sync;
    logic                          r_lrc_prev;
    logic [CW-1:0]                 r_bit_cnt;
    logic signed [SAMPLE_BITS-1:0] r_word;
    logic signed [SAMPLE_BITS-1:0] r_left;
    state_t                        r_state;
    state_t                        w_state_next;

    logic                          w_bclk_rise;
    logic                          w_lrc;
    logic                          w_dat;
    logic                          w_word_start;
    logic                          w_latch_left;
    logic                          w_push;
    logic signed [SAMPLE_BITS-1:0] w_word_next;

    logic signed [SAMPLE_BITS-1:0] r_mem_l [FIFO_DEPTH];
    logic signed [SAMPLE_BITS-1:0] r_mem_r [FIFO_DEPTH];
    logic [PW-1:0]                 r_wr_ptr;
    logic [PW-1:0]                 r_rd_ptr;
    logic [LW-1:0]                 r_level;
    logic                          r_overflow;
    logic                          w_full;
    logic                          w_pop;
    logic                          w_wr;
    logic                          w_drop;

    // bclk gets a third flop so its rising edge becomes a one-cycle pulse
    always_ff @(posedge mclk or negedge rstn) begin
        if (!rstn) begin
            r_bclk_sync <= '0;
            r_lrc_sync  <= '0;
            r_dat_sync  <= '0;
        end else begin
            r_bclk_sync <= {r_bclk_sync[1:0], audio_I2S_bclk};
            r_lrc_sync  <= {r_lrc_sync[0], audio_I2S_reclrc};
            r_dat_sync  <= {r_dat_sync[0], audio_I2S_recdat};
        end
    end

    assign w_bclk_rise  = r_bclk_sync[1] & ~r_bclk_sync[2];
    assign w_lrc        = r_lrc_sync[1];
    assign w_dat        = r_dat_sync[1];
    assign w_word_start = w_bclk_rise && (w_lrc != r_lrc_prev);

    always_comb begin
        w_word_next = r_word;
        for (int i = 0; i < SAMPLE_BITS; i++) begin
            if (r_bit_cnt == CW'(SAMPLE_BITS - 1 - i)) begin
                w_word_next[i] = w_dat;
            end
        end
    end

    // The bit coinciding with an lrc change belongs to the previous slot and is skipped
    always_ff @(posedge mclk or negedge rstn) begin
        if (!rstn) begin
            r_lrc_prev <= 1'b0;
            r_bit_cnt  <= '0;
            r_word     <= '0;
        end else if (w_bclk_rise) begin
            r_lrc_prev <= w_lrc;
            if (w_word_start) begin
                r_bit_cnt <= '0;
                r_word    <= '0;
            end else if (r_bit_cnt < CW'(SAMPLE_BITS)) begin
                r_word    <= w_word_next;
                r_bit_cnt <= r_bit_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge mclk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_latch_left = 1'b0;
        w_push       = 1'b0;
        if (!enable) begin
            w_state_next = ST_SYNC;
        end else if (w_word_start) begin
            case (r_state)
                ST_SYNC: begin
                    if (!w_lrc) w_state_next = ST_LEFT;
                end
                ST_LEFT: begin
                    if (w_lrc) begin
                        w_state_next = ST_RIGHT;
                        w_latch_left = 1'b1;
                    end
                end
                ST_RIGHT: begin
                    if (!w_lrc) begin
                        w_state_next = ST_LEFT;
                        w_push       = 1'b1;
                    end
                end
                default: w_state_next = ST_SYNC;
            endcase
        end
    end

    always_ff @(posedge mclk or negedge rstn) begin
        if (!rstn) begin
            r_left <= '0;
        end else if (w_latch_left) begin
            r_left <= r_word;
        end
    end

    // FIFO: a push into a full FIFO still lands when the head is popped in the same cycle
    assign w_full = (r_level == LW'(FIFO_DEPTH));
    assign w_pop  = (r_level != '0) && rec_ready;
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_drop = w_push && w_full && !w_pop;

    always_ff @(posedge mclk) begin
        if (w_wr) begin
            r_mem_l[r_wr_ptr] <= r_left;
            r_mem_r[r_wr_ptr] <= r_word;
        end
    end

    always_ff @(posedge mclk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign rec_valid  = (r_level != '0);
    assign rec_left   = rec_valid ? r_mem_l[r_rd_ptr] : '0;
    assign rec_right  = rec_valid ? r_mem_r[r_rd_ptr] : '0;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;

endmodule
